cache_victim_select: RTL and testbench
======================================

# cache_victim_select

Replacement-way allocator for the set-associative cache. Consumes the pseudo-random bits of the cache's LFSR and the set's valid state on a refill request, then returns one victim way over a valid/ack handshake. Invalid ways are always filled first. Otherwise the random index is used as the victim, skipping locked ways when locking is compiled in. Sits between the cache miss controller (requester) and the LFSR (random source).

## Interface
- WAYS, 4, associativity; power of two, 2..16
- IDX_W, $clog2(WAYS), width of way index and of the random input
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  refill request
- req_ready  out  1  allocator idle, can accept a request
- valid_mask  in  WAYS  per-way valid bits of the addressed set; sampled on accept
- lock_mask  in  WAYS  per-way lock bits; sampled on accept; port present only with CACHE_VICTIM_LOCK_EN
- rand_bits  in  IDX_W  LFSR low bits; sampled on accept
- victim_valid  out  1  result available
- victim_ack  in  1  requester consumed the result
- victim_way  out  IDX_W  selected way index
- victim_onehot  out  WAYS  one-hot form of victim_way; all-zero when victim_none=1
- victim_was_invalid  out  1  the selected way was invalid (no writeback needed)
- victim_none  out  1  no allocatable way (all candidates locked)

## Operation
- States: IDLE, SEARCH, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid: register valid_mask, lock_mask and rand_bits; set scan pointer = rand_bits; go to SEARCH.
- SEARCH, first cycle, invalid check:
  - Candidate set = ~valid_mask (& ~lock_mask with LOCK_EN).
  - If non-empty: victim = lowest index in the set, was_invalid=1; go to HOLD.
- SEARCH, otherwise:
  - Without LOCK_EN: victim = scan pointer; go to HOLD.
  - With LOCK_EN: test one way per cycle at the scan pointer.
    - Unlocked: select it; go to HOLD.
    - Locked: pointer = pointer+1, wrapping mod WAYS.
    - After WAYS locked tests: victim_none=1, victim_way=0; go to HOLD.
- HOLD:
  - victim_valid=1; all result outputs held stable.
  - On victim_ack: clear victim_valid, go to IDLE.
- victim_ack outside HOLD is ignored.
- req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Inputs change freely after accept; only the registered copies are used.
- Async reset, any state: state=IDLE, req_ready=1, victim_valid=0, victim_way=0, victim_onehot=0, victim_was_invalid=0, victim_none=0, scan pointer=0.

## Timing
- Cycle 0: accept edge (req_valid & req_ready).
- Cycle 1: SEARCH.
- Invalid-way hit, or no LOCK_EN: victim_valid high from cycle 2 (latency 2).
- LOCK_EN scan with k locked ways before the first unlocked: victim_valid from cycle 2+k, maximum 2+(WAYS-1).
- All locked: victim_none result at cycle 2+WAYS-1. It is asserted after the WAYS-th locked test, same cycle as that test's decision.
- Ack in the first HOLD cycle: req_ready high in the next cycle. The allocator is not pipelined; at most one request is in flight.
- All outputs are registered, or decoded from the state register only.

## Configuration
- CACHE_VICTIM_LOCK_EN:
  - Defined: lock_mask port exists; locked ways are excluded from both the invalid check and the scan; victim_none is reachable.
  - Undefined: no lock_mask port, no scan loop; victim_none is tied 0.

## Structure
- cache_pkg holds:
  - the victim state enum (IDLE/SEARCH/HOLD);
  - the default WAYS constant;
  - a way-index typedef sized by $clog2(WAYS);
  - a lowest-set-bit function used for the invalid check.
- No sub-module. The LFSR stays a separate instance in the cache top and feeds rand_bits.

## Test plan
- WAYS=4, valid_mask=1011, rand_bits=3, accept at cycle 0 -> cycle 2: victim_valid=1, victim_way=2, victim_onehot=0100, was_invalid=1.
- valid_mask=1111, rand_bits=1 -> cycle 2: victim_way=1, onehot=0010, was_invalid=0, victim_none=0.
- LOCK_EN, valid_mask=1111, lock_mask=0110, rand_bits=1 -> ways 1 and 2 skipped; cycle 4: victim_way=3.
- LOCK_EN, lock_mask=1111 -> cycle 5: victim_none=1, victim_way=0, onehot=0000.
- Hold victim_ack low for 5 cycles -> outputs stable, req_ready=0, extra req_valid ignored. Ack -> next cycle req_ready=1.
- Assert reset_n low during SEARCH of a LOCK_EN scan -> all outputs at reset values immediately. Release, then new request -> normal result at cycle 2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache replacement-way allocator.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_HOLD
  } victim_state_t;

  localparam int WAYS_DEFAULT = 4;

  typedef logic [$clog2(WAYS_DEFAULT)-1:0] way_idx_t;

  // Index of the lowest set bit; 0 when the mask is empty (callers test the mask first).
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Replacement-way allocator: fills invalid ways first, else uses the LFSR index.
// Way locking (lock_mask port, locked-way scan, victim_none) is enabled by CACHE_VICTIM_LOCK_EN.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int WAYS  = WAYS_DEFAULT,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WAYS-1:0]  valid_mask,
`ifdef CACHE_VICTIM_LOCK_EN
  input  logic [WAYS-1:0]  lock_mask,
`endif
  input  logic [IDX_W-1:0] rand_bits,
  output logic             victim_valid,
  input  logic             victim_ack,
  output logic [IDX_W-1:0] victim_way,
  output logic [WAYS-1:0]  victim_onehot,
  output logic             victim_was_invalid,
  output logic             victim_none
);

  localparam logic [WAYS-1:0] ONE_HOT0 = WAYS'(1);

  victim_state_t    state_reg;
  logic [WAYS-1:0]  valid_reg;
  logic [IDX_W-1:0] scan_ptr_reg;
  logic [WAYS-1:0]  cand;
  logic [15:0]      cand16;
  logic [IDX_W-1:0] first_free;

  assign req_ready    = (state_reg == ST_IDLE);
  assign victim_valid = (state_reg == ST_HOLD);

`ifdef CACHE_VICTIM_LOCK_EN
  logic [WAYS-1:0]  lock_reg;
  logic [IDX_W-1:0] test_cnt_reg;
  logic             none_reg;
  logic             ptr_locked;

  assign cand        = ~valid_reg & ~lock_reg;
  assign ptr_locked  = lock_reg[scan_ptr_reg];
  assign victim_none = none_reg;
`else
  assign cand        = ~valid_reg;
  assign victim_none = 1'b0;
`endif

  always_comb begin
    cand16             = '0;
    cand16[WAYS-1:0]   = cand;
    first_free         = IDX_W'(lowest_set(cand16));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= ST_IDLE;
      valid_reg          <= '0;
      scan_ptr_reg       <= '0;
      victim_way         <= '0;
      victim_onehot      <= '0;
      victim_was_invalid <= 1'b0;
`ifdef CACHE_VICTIM_LOCK_EN
      lock_reg           <= '0;
      test_cnt_reg       <= '0;
      none_reg           <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            valid_reg    <= valid_mask;
            scan_ptr_reg <= rand_bits;
`ifdef CACHE_VICTIM_LOCK_EN
            lock_reg     <= lock_mask;
            test_cnt_reg <= '0;
`endif
            state_reg    <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
`ifdef CACHE_VICTIM_LOCK_EN
          // The invalid check only counts on the first SEARCH cycle; later cycles are scan steps.
          if (test_cnt_reg == '0 && |cand) begin
            victim_way         <= first_free;
            victim_onehot      <= ONE_HOT0 << first_free;
            victim_was_invalid <= 1'b1;
            none_reg           <= 1'b0;
            state_reg          <= ST_HOLD;
          end else if (!ptr_locked) begin
            victim_way         <= scan_ptr_reg;
            victim_onehot      <= ONE_HOT0 << scan_ptr_reg;
            victim_was_invalid <= 1'b0;
            none_reg           <= 1'b0;
            state_reg          <= ST_HOLD;
          end else if (test_cnt_reg == IDX_W'(WAYS - 1)) begin
            victim_way         <= '0;
            victim_onehot      <= '0;
            victim_was_invalid <= 1'b0;
            none_reg           <= 1'b1;
            state_reg          <= ST_HOLD;
          end else begin
            scan_ptr_reg <= scan_ptr_reg + 1'b1;
            test_cnt_reg <= test_cnt_reg + 1'b1;
          end
`else
          if (|cand) begin
            victim_way         <= first_free;
            victim_onehot      <= ONE_HOT0 << first_free;
            victim_was_invalid <= 1'b1;
          end else begin
            victim_way         <= scan_ptr_reg;
            victim_onehot      <= ONE_HOT0 << scan_ptr_reg;
            victim_was_invalid <= 1'b0;
          end
          state_reg <= ST_HOLD;
`endif
        end
        ST_HOLD: begin
          if (victim_ack) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_victim_select.sv
// Self-checking bench for cache_victim_select (WAYS=4); follows CACHE_VICTIM_LOCK_EN if defined.
module tb_cache_victim_select;

  localparam int WAYS = 4;
`ifdef CACHE_VICTIM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] vm;
    logic [3:0] lm;
    logic [1:0] rb;
    logic [1:0] e_way;
    logic [3:0] e_oh;
    bit         e_inv;
    bit         e_none;
    int         e_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] valid_mask = '0;
  logic [3:0] lock_mask = '0;
  logic [1:0] rand_bits = '0;
  logic       victim_valid;
  logic       victim_ack = 1'b0;
  logic [1:0] victim_way;
  logic [3:0] victim_onehot;
  logic       victim_was_invalid;
  logic       victim_none;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_victim_select #(.WAYS(WAYS)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .valid_mask         (valid_mask),
`ifdef CACHE_VICTIM_LOCK_EN
    .lock_mask          (lock_mask),
`endif
    .rand_bits          (rand_bits),
    .victim_valid       (victim_valid),
    .victim_ack         (victim_ack),
    .victim_way         (victim_way),
    .victim_onehot      (victim_onehot),
    .victim_was_invalid (victim_was_invalid),
    .victim_none        (victim_none)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: invalid (unlocked) ways first, lowest index; else first unlocked way
  // walking upward from the random index, one cycle per way tested.
  function automatic void model(input logic [3:0] vm, input logic [3:0] lm, input logic [1:0] rb,
                                output logic [1:0] way, output logic [3:0] oh,
                                output bit inv, output bit none, output int lat);
    logic [3:0] lk;
    int w;
    lk = LOCK_EN ? lm : 4'b0000;
    way = 0; oh = 0; inv = 0; none = 0; lat = 2;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!vm[i] && !lk[i]) begin way = 2'(i); inv = 1; end
    if (inv) begin
      oh = 4'(1 << way);
      return;
    end
    none = 1;
    for (int k = WAYS - 1; k >= 0; k--) begin
      w = (int'(rb) + k) % WAYS;
      if (!lk[w]) begin way = 2'(w); lat = 2 + k; none = 0; end
    end
    if (none) begin
      way = 0; oh = 0; lat = 2 + WAYS - 1;
    end else begin
      oh = 4'(1 << way);
    end
  endfunction

  task automatic run_txn(input vec_t v, input int hold_cyc, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, "_ready_idle"}, int'(req_ready), 1);
    valid_mask = v.vm;
    lock_mask  = v.lm;
    rand_bits  = v.rb;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    valid_mask = 4'($urandom);
    lock_mask  = 4'($urandom);
    rand_bits  = 2'($urandom);
    chk({tag, "_ready_busy"}, int'(req_ready), 0);
    cyc = 1;
    while (!victim_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, v.e_lat);
    chk({tag, "_way"}, int'(victim_way), int'(v.e_way));
    chk({tag, "_onehot"}, int'(victim_onehot), int'(v.e_oh));
    chk({tag, "_was_invalid"}, int'(victim_was_invalid), int'(v.e_inv));
    chk({tag, "_none"}, int'(victim_none), int'(v.e_none));
    for (int h = 0; h < hold_cyc; h++) begin
      req_valid  = 1'b1;
      valid_mask = 4'($urandom);
      rand_bits  = 2'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, int'(victim_valid), 1);
      chk({tag, "_hold_ready"}, int'(req_ready), 0);
      chk({tag, "_hold_way"}, int'(victim_way), int'(v.e_way));
      chk({tag, "_hold_onehot"}, int'(victim_onehot), int'(v.e_oh));
    end
    req_valid  = 1'b0;
    victim_ack = 1'b1;
    @(posedge clk);
    #1;
    victim_ack = 1'b0;
    chk({tag, "_ack_ready"}, int'(req_ready), 1);
    chk({tag, "_ack_valid"}, int'(victim_valid), 0);
    $display("txn %s vm=%b lm=%b rb=%0d -> way=%0d oh=%b inv=%0d none=%0d lat=%0d",
             tag, v.vm, v.lm, v.rb, victim_way, victim_onehot, victim_was_invalid, victim_none, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rst_ready"}, int'(req_ready), 1);
    chk({tag, "_rst_valid"}, int'(victim_valid), 0);
    chk({tag, "_rst_way"}, int'(victim_way), 0);
    chk({tag, "_rst_onehot"}, int'(victim_onehot), 0);
    chk({tag, "_rst_inv"}, int'(victim_was_invalid), 0);
    chk({tag, "_rst_none"}, int'(victim_none), 0);
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    // Hand-derived table: {vm, lm, rb, way, onehot, was_invalid, none, latency}
    vecs.push_back('{4'b1011, 4'b0000, 2'd3, 2'd2, 4'b0100, 1, 0, 2});
    vecs.push_back('{4'b1111, 4'b0000, 2'd1, 2'd1, 4'b0010, 0, 0, 2});
    vecs.push_back('{4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0001, 1, 0, 2});
    vecs.push_back('{4'b0111, 4'b0000, 2'd0, 2'd3, 4'b1000, 1, 0, 2});
    vecs.push_back('{4'b1111, 4'b0000, 2'd3, 2'd3, 4'b1000, 0, 0, 2});
    vecs.push_back('{4'b1110, 4'b0000, 2'd3, 2'd0, 4'b0001, 1, 0, 2});
`ifdef CACHE_VICTIM_LOCK_EN
    vecs.push_back('{4'b1111, 4'b0110, 2'd1, 2'd3, 4'b1000, 0, 0, 4});
    vecs.push_back('{4'b1111, 4'b1111, 2'd2, 2'd0, 4'b0000, 0, 1, 5});
    vecs.push_back('{4'b1011, 4'b0100, 2'd0, 2'd0, 4'b0001, 0, 0, 2});
    vecs.push_back('{4'b0011, 4'b1000, 2'd3, 2'd2, 4'b0100, 1, 0, 2});
    vecs.push_back('{4'b1111, 4'b1011, 2'd3, 2'd2, 4'b0100, 0, 0, 5});
`endif

    #1;
    chk_reset_outputs("init");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_txn(vecs[i], (i == 1) ? 5 : 0, $sformatf("tbl%0d", i));

    // Leave nonzero results registered, then reset while the next request is searching.
    run_txn(vecs[3], 0, "pre_rst");
    @(negedge clk);
    valid_mask = 4'b1111;
    lock_mask  = 4'b1111;
    rand_bits  = 2'd2;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_search_ready", int'(req_ready), 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_search");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(vecs[1], 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.vm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      rv.lm = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      rv.rb = 2'($urandom);
      model(rv.vm, rv.lm, rv.rb, rv.e_way, rv.e_oh, rv.e_inv, rv.e_none, rv.e_lat);
      run_txn(rv, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
